// File: rtl/mem_copy_dma.sv
// mem_copy_dma: bus initiator that copies a block of 32-bit words, read then write, one word at a time.
// Optional ack timeout enabled by defining MEM_COPY_TIMEOUT_EN.
module mem_copy_dma #(
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 mem_rd_en_o,
    output logic                 mem_wr_en_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_data_o,
    input  logic [31:0]          mem_data_i,
    input  logic                 mem_ack_i
);
    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, FINISH} state_t;

    state_t               state, nxt;
    logic [31:0]          src, dst, src_n, dst_n;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 accept, rd_done, wr_done, expire, nxt_rd, nxt_wr;

    assign accept  = state == IDLE && start_i;
    assign rd_done = state == RD_WAIT && mem_ack_i;
    assign wr_done = state == WR_WAIT && mem_ack_i;
    assign src_n   = accept ? src_addr_i & ~32'd3 : wr_done ? src + 32'd4 : src;
    assign dst_n   = accept ? dst_addr_i & ~32'd3 : wr_done ? dst + 32'd4 : dst;
    assign nxt_rd  = nxt == RD_ISSUE || nxt == RD_WAIT;
    assign nxt_wr  = nxt == WR_ISSUE || nxt == WR_WAIT;

`ifdef MEM_COPY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] wait_cnt;
    assign expire = (state == RD_WAIT || state == WR_WAIT) && !mem_ack_i &&
                    wait_cnt == TW'(TIMEOUT_CYCLES - 1);
    // Counts consecutive wait cycles; the single ISSUE cycle before each wait clears it.
    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else
            wait_cnt <= (state == RD_WAIT || state == WR_WAIT) ? wait_cnt + TW'(1) : '0;
    end
`else
    // No timeout in this build; the waits last until ack arrives.
    assign expire = TIMEOUT_CYCLES < 0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (start_i) nxt = len_i == '0 ? FINISH : RD_ISSUE;
            RD_ISSUE: nxt = RD_WAIT;
            RD_WAIT:  nxt = mem_ack_i ? WR_ISSUE : expire ? FINISH : RD_WAIT;
            WR_ISSUE: nxt = WR_WAIT;
            WR_WAIT:  nxt = mem_ack_i ? (remaining == LEN_WIDTH'(1) ? FINISH : RD_ISSUE) :
                            expire ? FINISH : WR_WAIT;
            FINISH:   nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // Request outputs are decoded from the next state so they line up with the ISSUE/WAIT states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            src         <= '0;
            dst         <= '0;
            remaining   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            mem_rd_en_o <= 1'b0;
            mem_wr_en_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_data_o  <= '0;
        end else begin
            state       <= nxt;
            src         <= src_n;
            dst         <= dst_n;
            remaining   <= accept ? len_i : wr_done ? remaining - LEN_WIDTH'(1) : remaining;
            busy_o      <= nxt != IDLE;
            done_o      <= state == FINISH;
            err_o       <= accept ? 1'b0 : expire ? 1'b1 : err_o;
            mem_rd_en_o <= nxt_rd;
            mem_wr_en_o <= nxt_wr;
            mem_addr_o  <= nxt_rd ? src_n : nxt_wr ? dst_n : '0;
            if (rd_done) mem_data_o <= mem_data_i;
        end
    end
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: randomized copies against a word-level copy model, plus directed literal checks.
module tb_mem_copy_dma;
    logic        clk = 0, rst = 1, start_i = 0;
    logic [31:0] src_addr_i = 0, dst_addr_i = 0;
    logic [15:0] len_i = 0;
    logic        busy_o, done_o, err_o, mem_rd_en_o, mem_wr_en_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [31:0] mem_data_i = 0;
    logic        mem_ack_i = 0;

    mem_copy_dma #(.LEN_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i),
        .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .mem_rd_en_o(mem_rd_en_o),
        .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    logic [31:0] mem [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];
    function automatic logic [31:0] init_word(logic [29:0] a);
        return {a, 2'b00} ^ 32'h5A5A_1234;
    endfunction
    function automatic logic [31:0] mem_rd(logic [29:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction
    function automatic logic [31:0] ref_rd(logic [29:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Memory responder: data/writes handled mid-cycle, ack either 1-cycle or random latency.
    bit fast_mode = 1, never_ack = 0;
    int lat = 1, cnt = 0;
    always @(negedge clk) begin
        if (mem_wr_en_o) mem[mem_addr_o[31:2]] = mem_data_o;
        mem_data_i = mem_rd_en_o ? mem_rd(mem_addr_o[31:2]) : 32'hBAD0_BAD0;
    end
    always @(posedge clk) begin
        if (rst) begin
            mem_ack_i <= 0;
            cnt <= 0;
        end else if (never_ack)
            mem_ack_i <= 0;
        else if (fast_mode)
            mem_ack_i <= mem_rd_en_o || mem_wr_en_o;
        else if (!(mem_rd_en_o || mem_wr_en_o) || mem_ack_i) begin
            mem_ack_i <= 0;
            cnt <= 0;
        end else if (cnt + 1 >= lat) begin
            mem_ack_i <= 1;
            cnt <= 0;
            lat <= $urandom_range(1, 3);
        end else
            cnt <= cnt + 1;
    end

    // Reference model: an ordered list of word operations per transfer, requests back to back.
    typedef struct packed {logic wr; logic [31:0] addr;} op_t;
    op_t ops[$];
    logic [31:0] rd_addrs[$];
    bit          model_on = 1, active = 0, exp_err = 0, prev_rd = 0, prev_wr = 0;
    bit          req_exp, busy_exp, head_wr;
    logic [31:0] head_addr, wdata_exp = 0, ms, md;
    int          start_c = 0, done_due = -1, rd_cnt = 0, wr_cnt = 0, req_cycles = 0;

    always @(negedge clk) begin
        if (mem_rd_en_o || mem_wr_en_o) req_cycles++;
        if (model_on) begin
            req_exp   = active && ops.size() > 0 && cyc > start_c;
            head_wr   = ops.size() > 0 && ops[0].wr;
            head_addr = ops.size() > 0 ? ops[0].addr : 32'd0;
            busy_exp  = active && cyc > start_c && (done_due < 0 || cyc < done_due);
            chk("busy", busy_o, busy_exp);
            chk("done", done_o, active && cyc == done_due);
            chk("err", err_o, exp_err);
            chk("rd_en", mem_rd_en_o, req_exp && !head_wr);
            chk("wr_en", mem_wr_en_o, req_exp && head_wr);
            chk("rd_wr_excl", mem_rd_en_o && mem_wr_en_o, 0);
            if (req_exp) begin
                chk("addr", mem_addr_o, head_addr);
                if (head_wr) chk("wdata", mem_data_o, wdata_exp);
                if (mem_ack_i && (head_wr ? mem_wr_en_o && prev_wr : mem_rd_en_o && prev_rd)) begin
                    if (head_wr) begin
                        ref_mem[head_addr[31:2]] = wdata_exp;
                        wr_cnt++;
                    end else begin
                        wdata_exp = ref_rd(head_addr[31:2]);
                        rd_cnt++;
                        rd_addrs.push_back(head_addr);
                    end
                    void'(ops.pop_front());
                    if (ops.size() == 0) done_due = cyc + 2;
                end
            end
            if (active && cyc == done_due) active = 0;
            if (rst) begin
                active = 0;
                ops.delete();
                done_due = -1;
                exp_err = 0;
            end else if (start_i && !active) begin
                ms = src_addr_i & ~32'd3;
                md = dst_addr_i & ~32'd3;
                for (int i = 0; i < int'(len_i); i++) begin
                    ops.push_back('{1'b0, ms + 32'(4 * i)});
                    ops.push_back('{1'b1, md + 32'(4 * i)});
                end
                start_c = cyc;
                done_due = len_i == 0 ? cyc + 2 : -1;
                active = 1;
                exp_err = 0;
            end
        end
        prev_rd = mem_rd_en_o;
        prev_wr = mem_wr_en_o;
    end

    task automatic pulse_start(logic [31:0] s, logic [31:0] d, logic [15:0] l, output int st);
        @(posedge clk); #1;
        src_addr_i = s; dst_addr_i = d; len_i = l; start_i = 1; st = cyc;
        @(posedge clk); #1;
        start_i = 0; src_addr_i = $urandom; dst_addr_i = $urandom; len_i = 16'($urandom);
    endtask

    task automatic wait_done(output int dc);
        bit got = 0;
        dc = -1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (done_o) begin got = 1; dc = cyc; end
        end
        if (!got) chk("done_timeout", 0, 1);
    endtask

    int st, st2, dc;
    logic [31:0] exp5 [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_busy", busy_o, 0); chk("rst_done", done_o, 0); chk("rst_rd", mem_rd_en_o, 0);
        chk("rst_wr", mem_wr_en_o, 0); chk("rst_addr", mem_addr_o, 0); chk("rst_data", mem_data_o, 0);

        // Four-word copy against the 1-cycle-ack memory.
        for (int i = 0; i < 4; i++) begin
            mem[30'h40 + 30'(i)] = 32'hA0A0_0000 + 32'(i);
            ref_mem[30'h40 + 30'(i)] = 32'hA0A0_0000 + 32'(i);
        end
        rd_cnt = 0; wr_cnt = 0;
        pulse_start(32'h100, 32'h200, 4, st);
        wait_done(dc);
        chk("t2_done_cycle", dc - st, 18);
        chk("t2_rd_acks", rd_cnt, 4);
        chk("t2_wr_acks", wr_cnt, 4);
        for (int i = 0; i < 4; i++) chk("t2_mem", mem_rd(30'h80 + 30'(i)), 32'hA0A0_0000 + 32'(i));

        // Zero length: no traffic.
        req_cycles = 0;
        pulse_start(32'h100, 32'h200, 0, st);
        wait_done(dc);
        chk("t3_done_cycle", dc - st, 2);
        chk("t3_no_req", req_cycles, 0);

        // Second start while busy is ignored.
        rd_cnt = 0; wr_cnt = 0;
        pulse_start(32'h300, 32'h400, 2, st);
        pulse_start(32'h500, 32'h700, 3, st2);
        wait_done(dc);
        req_cycles = 0;
        repeat (20) @(negedge clk);
        chk("t4_rd_acks", rd_cnt, 2);
        chk("t4_wr_acks", wr_cnt, 2);
        chk("t4_no_more_req", req_cycles, 0);

        // Source address wrap.
        rd_addrs.delete();
        pulse_start(32'hFFFF_FFF8, 32'h600, 3, st);
        wait_done(dc);
        chk("t5_nreads", rd_addrs.size(), 3);
        for (int i = 0; i < 3; i++) chk("t5_rd_addr", rd_addrs.size() > i ? rd_addrs[i] : 32'hX, exp5[i]);

        // Reset held three cycles mid-copy.
        fast_mode = 0;
        pulse_start(32'h8000, 32'h9000, 5, st);
        repeat (6) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        @(negedge clk);
        chk("t1_busy", busy_o, 0); chk("t1_done", done_o, 0); chk("t1_rd", mem_rd_en_o, 0);
        chk("t1_wr", mem_wr_en_o, 0); chk("t1_addr", mem_addr_o, 0); chk("t1_data", mem_data_o, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
        req_cycles = 0;
        repeat (5) @(negedge clk);
        chk("t1_quiet", req_cycles, 0);
        wr_cnt = 0;
        pulse_start(32'h8000, 32'hA000, 2, st);
        wait_done(dc);
        chk("t1_restart_wr", wr_cnt, 2);

`ifdef MEM_COPY_TIMEOUT_EN
        model_on = 0; never_ack = 1;
        pulse_start(32'h100, 32'h200, 3, st);
        wait_done(dc);
        chk("t6_done_cycle", dc - st, 11);
        chk("t6_err", err_o, 1);
        chk("t6_busy", busy_o, 0);
        @(negedge clk);
        chk("t6_err_sticky", err_o, 1);
        never_ack = 0; fast_mode = 1;
        active = 0; ops.delete(); done_due = -1; exp_err = 1; model_on = 1;
        pulse_start(32'h4000, 32'h4800, 1, st);
        wait_done(dc);
        chk("t6_err_cleared", err_o, 0);
`endif

        // Randomized copies with mixed ack timing and stray start pulses.
        for (int k = 0; k < 25; k++) begin
            fast_mode = 1'($urandom_range(0, 1));
            ms = k % 6 == 5 ? 32'hFFFF_FFF0 : 32'h4000 + 32'($urandom_range(0, 255)) * 4;
            pulse_start(ms | 32'($urandom_range(0, 3)),
                        32'h4000 + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3)),
                        16'($urandom_range(0, 6)), st);
            if ($urandom_range(0, 1) == 1)
                pulse_start(32'h4400, 32'h4C00, 16'($urandom_range(1, 3)), st2);
            wait_done(dc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        for (int i = 0; i < 300 && (active || busy_o); i++) @(negedge clk);
        chk("final_idle", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
